// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline constants for the hazard/debug control stage.
// Holds the FSM state encoding, the HALT opcode, the register-zero index
// and the packed control-output bundle used by the top module.
package hazard_control_unit_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned ST_W  = 3;

   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_RUN    = 3'd1;
   localparam logic [ST_W-1:0] ST_STEP   = 3'd2;
   localparam logic [ST_W-1:0] ST_DRAIN  = 3'd3;
   localparam logic [ST_W-1:0] ST_HALTED = 3'd4;

   localparam logic [5:0]       OP_HALT  = 6'b111111;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Control bundle driven towards the pipeline registers each cycle
   typedef struct packed {
      logic pipe_en;
      logic pc_wr_en;
      logic if_id_wr_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic halted;
   } ctl_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bus between the ID/EX pipeline datapath and the hazard control unit.
// slave  : the control unit (consumes stage info, drives controls/counters).
// master : the pipeline side.
interface hazard_control_unit_if #(
   parameter int unsigned CNT_W = 32
) ();
   import hazard_control_unit_pkg::*;

   logic [REG_W-1:0] i_rs_ID;
   logic [REG_W-1:0] i_rt_ID;
   logic             i_flg_uses_rt_ID;
   logic [REG_W-1:0] i_rt_EX;
   logic             i_flg_mem_rd_EX;
   logic             i_flg_branch_taken_EX;
   logic             i_flg_halt_ID;
   logic             i_dbg_run;
   logic             i_dbg_step;

   logic             o_pipe_en;
   logic             o_pc_wr_en;
   logic             o_IF_ID_wr_en;
   logic             o_IF_ID_flush;
   logic             o_ID_EX_flush;
   logic             o_halted;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_cycle_cnt;

   modport slave (
      input  i_rs_ID, i_rt_ID, i_flg_uses_rt_ID, i_rt_EX, i_flg_mem_rd_EX,
             i_flg_branch_taken_EX, i_flg_halt_ID, i_dbg_run, i_dbg_step,
      output o_pipe_en, o_pc_wr_en, o_IF_ID_wr_en, o_IF_ID_flush,
             o_ID_EX_flush, o_halted, o_stall_cnt, o_cycle_cnt
   );

   modport master (
      output i_rs_ID, i_rt_ID, i_flg_uses_rt_ID, i_rt_EX, i_flg_mem_rd_EX,
             i_flg_branch_taken_EX, i_flg_halt_ID, i_dbg_run, i_dbg_step,
      input  o_pipe_en, o_pc_wr_en, o_IF_ID_wr_en, o_IF_ID_flush,
             o_ID_EX_flush, o_halted, o_stall_cnt, o_cycle_cnt
   );

endinterface

// File: rtl/hazard_control_unit_load_use_detector.sv
// Combinational load-use hazard detector.
// Flags when the load in EX writes a register the instruction in ID reads.
// Ports: rs_id/rt_id/uses_rt_id (ID sources), rt_ex/mem_rd_ex (EX load),
//        hazard_c (bubble required).
module load_use_detector
   import hazard_control_unit_pkg::*;
(
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   input  logic             uses_rt_id,
   input  logic [REG_W-1:0] rt_ex,
   input  logic             mem_rd_ex,
   output logic             hazard_c
);

   // $zero is never a real dependency
   assign hazard_c = mem_rd_ex && (rt_ex != REG_ZERO) &&
                     ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard and debug control for the 5-stage core.
// Inserts load-use bubbles, flushes wrong-path work on taken branches and
// sequences debug run/step/halt, draining the pipeline after HALT.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave side of
//        hazard_control_unit_if: stage info in, enables/flushes/counters out).
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   hazard_control_unit_if.slave  bus
);

   localparam int unsigned      DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [ST_W-1:0]  state_q, state_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             step_q;
   logic             step_rise_c;
   logic             load_use_c;
   logic             stall_c;
   ctl_t             ctl_c;

   load_use_detector u_load_use (
      .rs_id      (bus.i_rs_ID),
      .rt_id      (bus.i_rt_ID),
      .uses_rt_id (bus.i_flg_uses_rt_ID),
      .rt_ex      (bus.i_rt_EX),
      .mem_rd_ex  (bus.i_flg_mem_rd_EX),
      .hazard_c   (load_use_c)
   );

   assign step_rise_c = bus.i_dbg_step && !step_q;

   // State, drain counter, step edge history and performance counters
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         drain_q <= '0;
         cycle_q <= '0;
         stall_q <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         cycle_q <= cycle_d;
         stall_q <= stall_d;
         step_q  <= bus.i_dbg_step;
      end
   end

   // Next state and per-cycle controls
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      ctl_c   = '0;
      stall_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_dbg_run) begin
               state_d = ST_RUN;
            end else if (step_rise_c) begin
               state_d = ST_STEP;
            end
         end

         ST_RUN, ST_STEP: begin
            ctl_c.pipe_en = 1'b1;
            // A taken branch squashes whatever sits in ID, HALT included
            if (bus.i_flg_branch_taken_EX) begin
               ctl_c.pc_wr_en    = 1'b1;
               ctl_c.if_id_wr_en = 1'b1;
               ctl_c.if_id_flush = 1'b1;
               ctl_c.id_ex_flush = 1'b1;
            end else if (bus.i_flg_halt_ID) begin
               ctl_c.if_id_flush = 1'b1;
               ctl_c.id_ex_flush = 1'b1;
            end else if (load_use_c) begin
               ctl_c.id_ex_flush = 1'b1;
               stall_c           = 1'b1;
            end else begin
               ctl_c.pc_wr_en    = 1'b1;
               ctl_c.if_id_wr_en = 1'b1;
            end

            if (!bus.i_flg_branch_taken_EX && bus.i_flg_halt_ID) begin
               state_d = ST_DRAIN;
               drain_d = DRN_LOAD;
            end else if ((state_q == ST_STEP) || !bus.i_dbg_run) begin
               state_d = ST_IDLE;
            end
         end

         // Let EX/MEM/WB retire while fetch stays frozen; run/step ignored
         ST_DRAIN: begin
            ctl_c.pipe_en     = 1'b1;
            ctl_c.if_id_flush = 1'b1;
            if (drain_q == '0) begin
               state_d = ST_HALTED;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end

         ST_HALTED: begin
            ctl_c.halted = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cycle_d = (ctl_c.pipe_en && (cycle_q != CNT_MAX)) ? cycle_q + CNT_W'(1) : cycle_q;
      stall_d = (stall_c && (stall_q != CNT_MAX)) ? stall_q + CNT_W'(1) : stall_q;
   end

   assign bus.o_pipe_en     = ctl_c.pipe_en;
   assign bus.o_pc_wr_en    = ctl_c.pc_wr_en;
   assign bus.o_IF_ID_wr_en = ctl_c.if_id_wr_en;
   assign bus.o_IF_ID_flush = ctl_c.if_id_flush;
   assign bus.o_ID_EX_flush = ctl_c.id_ex_flush;
   assign bus.o_halted      = ctl_c.halted;
   assign bus.o_cycle_cnt   = cycle_q;
   assign bus.o_stall_cnt   = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a queue-based scoreboard.
module tb_hazard_control_unit;

   localparam int unsigned CNT_W = 32;

   // {pipe_en, pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush, halted}
   localparam logic [5:0] C_IDLE   = 6'b000000;
   localparam logic [5:0] C_NONE   = 6'b111000;
   localparam logic [5:0] C_STALL  = 6'b100010;
   localparam logic [5:0] C_BR     = 6'b111110;
   localparam logic [5:0] C_HALT   = 6'b100110;
   localparam logic [5:0] C_DRAIN  = 6'b100100;
   localparam logic [5:0] C_HALTED = 6'b000001;

   typedef struct packed {
      logic [5:0]       ctl;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] cyc;
   } exp_t;

   logic clk;
   logic rst_n;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_vec  = 0;
   int    n_miss = 0;

   hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

   hazard_control_unit #(
      .DRAIN_CYCLES (3),
      .CNT_W        (CNT_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string name, input logic [5:0] ctl,
                           input int stall, input int cyc);
      exp_t e;
      e.ctl   = ctl;
      e.stall = CNT_W'(stall);
      e.cyc   = CNT_W'(cyc);
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Monitor: compares the DUT against the oldest expectation each cycle
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t  e;
         string nm;
         logic [5:0] act;
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {bus.o_pipe_en, bus.o_pc_wr_en, bus.o_IF_ID_wr_en,
                bus.o_IF_ID_flush, bus.o_ID_EX_flush, bus.o_halted};
         n_vec++;
         if (act !== e.ctl || bus.o_stall_cnt !== e.stall || bus.o_cycle_cnt !== e.cyc) begin
            n_miss++;
            $display("FAIL %s: ctl=%b stall=%0d cycle=%0d, required ctl=%b stall=%0d cycle=%0d",
                     nm, act, bus.o_stall_cnt, bus.o_cycle_cnt, e.ctl, e.stall, e.cyc);
         end
      end
   end

   initial begin
      rst_n                     = 1'b0;
      bus.i_rs_ID               = '0;
      bus.i_rt_ID               = '0;
      bus.i_flg_uses_rt_ID      = 1'b0;
      bus.i_rt_EX               = '0;
      bus.i_flg_mem_rd_EX       = 1'b0;
      bus.i_flg_branch_taken_EX = 1'b0;
      bus.i_flg_halt_ID         = 1'b0;
      bus.i_dbg_run             = 1'b0;
      bus.i_dbg_step            = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state, then free-run with no hazards
      tick(); rst_n = 1'b1; bus.i_dbg_run = 1'b1;
      expect_v("reset", C_IDLE, 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick(); expect_v("run_clean", C_NONE, 0, i);
      end

      // Load-use on rs, $zero exclusion, rt without rt use, rt with use
      tick(); bus.i_flg_mem_rd_EX = 1'b1; bus.i_rt_EX = 5'd2; bus.i_rs_ID = 5'd2;
      expect_v("load_use_rs", C_STALL, 0, 10);
      tick(); bus.i_rt_EX = 5'd0; bus.i_rs_ID = 5'd0;
      expect_v("load_rt_zero", C_NONE, 1, 11);
      tick(); bus.i_rt_EX = 5'd3; bus.i_rt_ID = 5'd3; bus.i_rs_ID = 5'd5;
      expect_v("rt_not_used", C_NONE, 1, 12);
      tick(); bus.i_flg_uses_rt_ID = 1'b1;
      expect_v("load_use_rt", C_STALL, 1, 13);

      // Branch beats load-use and HALT
      tick(); bus.i_flg_branch_taken_EX = 1'b1;
      expect_v("branch_over_lu", C_BR, 2, 14);
      tick(); bus.i_flg_halt_ID = 1'b1; bus.i_flg_mem_rd_EX = 1'b0;
      expect_v("branch_over_halt", C_BR, 2, 15);
      tick(); bus.i_flg_branch_taken_EX = 1'b0; bus.i_flg_halt_ID = 1'b0;
      expect_v("no_drain", C_NONE, 2, 16);

      // HALT, three drain cycles ignoring run/step, then halted for good
      tick(); bus.i_flg_halt_ID = 1'b1;
      expect_v("halt", C_HALT, 2, 17);
      tick(); bus.i_flg_halt_ID = 1'b0; bus.i_dbg_run = 1'b0;
      expect_v("drain1", C_DRAIN, 2, 18);
      tick(); bus.i_dbg_step = 1'b1;
      expect_v("drain2", C_DRAIN, 2, 19);
      tick(); bus.i_dbg_step = 1'b0; bus.i_dbg_run = 1'b1;
      expect_v("drain3", C_DRAIN, 2, 20);
      tick(); bus.i_dbg_run = 1'b0; bus.i_dbg_step = 1'b1;
      expect_v("halted_step", C_HALTED, 2, 21);
      tick(); bus.i_dbg_step = 1'b0; bus.i_dbg_run = 1'b1;
      expect_v("halted_run", C_HALTED, 2, 21);
      tick(); bus.i_dbg_run = 1'b0;
      expect_v("halted_idle", C_HALTED, 2, 21);

      // Reset out of HALTED, then single stepping
      tick(); rst_n = 1'b0;
      expect_v("rst_in_halted", C_HALTED, 2, 21);
      tick(); rst_n = 1'b1;
      expect_v("post_rst", C_IDLE, 0, 0);
      tick(); bus.i_dbg_step = 1'b1;
      expect_v("step_rise", C_IDLE, 0, 0);
      tick(); expect_v("step_exec", C_NONE, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); expect_v("step_held", C_IDLE, 0, 1);
      end
      tick(); bus.i_dbg_step = 1'b0;
      expect_v("step_once", C_IDLE, 0, 1);
      tick(); bus.i_dbg_step = 1'b1;
      expect_v("step2_rise", C_IDLE, 0, 1);
      tick(); bus.i_dbg_step = 1'b0;
      expect_v("step2_exec", C_NONE, 0, 1);
      tick(); expect_v("step_twice", C_IDLE, 0, 2);

      // Reset during the second drain cycle abandons the drain
      tick(); bus.i_dbg_run = 1'b1;
      expect_v("run_again", C_IDLE, 0, 2);
      tick(); bus.i_flg_halt_ID = 1'b1;
      expect_v("halt2", C_HALT, 0, 2);
      tick(); bus.i_flg_halt_ID = 1'b0;
      expect_v("drain_a", C_DRAIN, 0, 3);
      tick(); rst_n = 1'b0;
      expect_v("drain_b_rst", C_DRAIN, 0, 4);
      tick(); rst_n = 1'b1; bus.i_dbg_run = 1'b0;
      expect_v("after_rst", C_IDLE, 0, 0);
      tick(); expect_v("no_resume", C_IDLE, 0, 0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline control stage in the ID stage, alongside the EX-stage forwarding logic, for the 5-stage MIPS core.
- Detects load-use hazards that forwarding cannot cover and inserts a one-cycle bubble.
- Flushes wrong-path instructions on taken branches.
- Runs the debug run/step/halt sequencing, draining the pipeline after a HALT.
- Drives PC and IF/ID write enables, IF/ID and ID/EX flush, and a global stage enable.

Parameters:
- DRAIN_CYCLES, 3, cycles the pipeline keeps running after HALT leaves ID (EX, MEM, WB).
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_rs_ID, i_rt_ID  in  5  source register fields of the instruction in ID.
- i_flg_uses_rt_ID  in  1  instruction in ID reads rt as a source.
- i_rt_EX  in  5  destination (rt) of the instruction in EX.
- i_flg_mem_rd_EX  in  1  instruction in EX is a load.
- i_flg_branch_taken_EX  in  1  branch/jump in EX resolved taken.
- i_flg_halt_ID  in  1  HALT opcode in ID.
- i_dbg_run  in  1  level: free-run while high.
- i_dbg_step  in  1  step request; acted on at its rising edge.
- o_pipe_en  out  1  global enable for all stage registers.
- o_pc_wr_en, o_IF_ID_wr_en  out  1  PC / IF-ID write enables.
- o_IF_ID_flush, o_ID_EX_flush  out  1  load a NOP into the stage register.
- o_halted  out  1  pipeline drained after HALT.
- o_stall_cnt, o_cycle_cnt  out  CNT_W  load-use bubbles inserted / enabled cycles executed.

Behaviour:
Reset (i_rst_n=0 at a rising edge):
- state=IDLE, counters=0, step edge register=0, drain counter=0.
- All outputs 0.

FSM states:
- IDLE: o_pipe_en=0, other controls 0.
  - i_dbg_run=1 -> RUN.
  - Otherwise, a rising edge of i_dbg_step (step high, registered previous step low) -> STEP.
  - Run has priority over step.
- RUN: o_pipe_en=1.
  - HALT detected -> DRAIN.
  - Otherwise, i_dbg_run=0 -> IDLE.
- STEP: o_pipe_en=1 for exactly one cycle.
  - HALT detected -> DRAIN, else -> IDLE.
  - A step held high yields exactly one step.
- DRAIN: o_pipe_en=1, o_pc_wr_en=0, o_IF_ID_flush=1; drain counter loaded with DRAIN_CYCLES-1 on entry.
  - Counts down every cycle, ignoring run/step.
  - At 0 -> HALTED.
  - Exactly DRAIN_CYCLES cycles are spent in DRAIN.
- HALTED: o_pipe_en=0, o_halted=1, all other controls 0. Left only by reset.

Hazard decode (combinational, evaluated only when state is RUN or STEP; all 0 otherwise except as stated for DRAIN).
Priority, highest first:
1. Branch: i_flg_branch_taken_EX=1.
   - o_IF_ID_flush=1, o_ID_EX_flush=1, o_pc_wr_en=1, o_IF_ID_wr_en=1.
   - Any HALT or load-use hazard in ID is squashed and ignored.
2. HALT detected: i_flg_halt_ID=1.
   - o_pc_wr_en=0, o_IF_ID_flush=1, o_ID_EX_flush=1 (HALT travels as a NOP).
   - FSM moves to DRAIN next cycle.
3. Load-use: i_flg_mem_rd_EX & (i_rt_EX!=0) & ((i_rt_EX==i_rs_ID) | (i_flg_uses_rt_ID & i_rt_EX==i_rt_ID)).
   - o_pc_wr_en=0, o_IF_ID_wr_en=0, o_ID_EX_flush=1 for that cycle.
   - The next cycle re-evaluates normally; the load has moved to MEM, so the hazard clears.
4. None: o_pc_wr_en=1, o_IF_ID_wr_en=1, flushes 0.

Counters:
- o_cycle_cnt increments on every cycle with o_pipe_en=1, including DRAIN.
- o_stall_cnt increments on every cycle where a load-use bubble is inserted (case 3 only).
- Both saturate at all-ones; no wrap.

Reset mid-operation (any state, including DRAIN or HALTED):
- Returns to IDLE and clears counters on that edge.
- The drain sequence is abandoned.

Decomposition:
- Shared pipeline package: state encoding (IDLE, RUN, STEP, DRAIN, HALTED), HALT opcode constant, register-zero constant.
- One sub-module is natural: load_use_detector. Purely combinational; compares ID sources against the EX load destination. Reusable when a MEM-stage load path is added later.
- The FSM, step edge detect and counters stay in the top module.

Test Plan:
1. Reset, then i_dbg_run=1 with no hazards for 10 cycles -> o_pipe_en=1 and o_pc_wr_en=1 every cycle, o_cycle_cnt=10, o_stall_cnt=0.
2. Load-use: RUN, i_flg_mem_rd_EX=1, i_rt_EX=2, i_rs_ID=2 -> for that cycle o_pc_wr_en=0, o_IF_ID_wr_en=0, o_ID_EX_flush=1, and o_stall_cnt 0->1.
   - Repeat with i_rt_EX=0, and with rt match but i_flg_uses_rt_ID=0 -> no stall.
3. Taken branch and load-use in the same cycle -> both flushes=1, o_pc_wr_en=1, o_stall_cnt unchanged.
   - Taken branch with i_flg_halt_ID=1 -> no DRAIN entry.
4. HALT in RUN -> one cycle with both flushes=1 and o_pc_wr_en=0, then 3 DRAIN cycles with o_pipe_en=1 and o_pc_wr_en=0.
   - Then o_halted=1 and o_pipe_en=0; toggling run/step changes nothing.
5. Step mode: i_dbg_run=0, i_dbg_step held high 5 cycles -> exactly one cycle with o_pipe_en=1, o_cycle_cnt=1.
   - Drop step, raise it again -> o_cycle_cnt=2.
6. i_rst_n=0 during the second DRAIN cycle -> next cycle state IDLE, o_halted=0, all counters 0, o_pipe_en=0.
